// File: rtl/rx_ts_decoder_pkg.sv
// Shared constants, FSM encoding and field record for the Gen1/Gen2 TS1/TS2 decoder.
// Imported by the per-lane parser and by the top level.
package rx_ts_decoder_pkg;

    localparam int LANES        = 16;
    localparam int SYM_PER_LANE = 4;

    localparam logic [3:0] CONSEC_MAX = 4'd15;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam logic [7:0] PAD_SYM = 8'hF7;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;

    localparam logic [2:0] GEN1 = 3'd1;
    localparam logic [2:0] GEN2 = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ID   = 2'd2
    } ts_state_e;

    // Everything that must match for two TSs to count as identical.
    typedef struct packed {
        logic       ts2;
        logic       link_pad;
        logic [7:0] link;
        logic       lane_pad;
        logic [7:0] lane;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] ctrl;
    } ts_fields_t;

endpackage

// File: rtl/rx_ts_decoder_lane.sv
// One lane of the training-set decoder: symbol-serial TS1/TS2 parser with field capture
// and a saturating consecutive-identical-TS counter.
module ts_lane_parser
    import rx_ts_decoder_pkg::*;
(
    input  logic                      clk,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic                      valid_i,
    input  logic [SYM_PER_LANE*8-1:0] data_i,
    input  logic [SYM_PER_LANE-1:0]   datak_i,
    output logic                      ts_valid_o,
    output ts_fields_t                fields_o,
    output logic [3:0]                ts_count_o
);

    ts_state_e  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    ts_fields_t cur_q, cur_d;
    ts_fields_t last_q, last_d;
    ts_fields_t fields_q, fields_d;
    logic [3:0] count_q, count_d;
    logic       done_q, done_d;

    logic [7:0] sym;
    logic       sym_k;
    logic       sym_com;
    logic       sym_ok;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cur_d    = cur_q;
        last_d   = last_q;
        fields_d = fields_q;
        count_d  = count_q;
        done_d   = 1'b0;
        sym      = '0;
        sym_k    = 1'b0;
        sym_com  = 1'b0;
        sym_ok   = 1'b0;
        if (valid_i) begin
            for (int s = 0; s < SYM_PER_LANE; s++) begin
                sym     = data_i[s*8 +: 8];
                sym_k   = datak_i[s];
                sym_com = sym_k && (sym == COM_SYM);
                sym_ok  = 1'b0;
                if (state_d == ST_IDLE) begin
                    if (sym_com) begin
                        state_d = ST_HDR;
                        idx_d   = 4'd1;
                    end
                end else begin
                    case (idx_d)
                        4'd1, 4'd2:       sym_ok = !sym_k || (sym == PAD_SYM);
                        4'd3, 4'd4, 4'd5: sym_ok = !sym_k;
                        4'd6:             sym_ok = !sym_k && ((sym == TS1_ID) || (sym == TS2_ID));
                        default:          sym_ok = !sym_k && (sym == (cur_d.ts2 ? TS2_ID : TS1_ID));
                    endcase
                    case (idx_d)
                        4'd1: begin
                            cur_d.link     = sym;
                            cur_d.link_pad = sym_k;
                        end
                        4'd2: begin
                            cur_d.lane     = sym;
                            cur_d.lane_pad = sym_k;
                        end
                        4'd3:    cur_d.nfts = sym;
                        4'd4:    cur_d.rate = sym;
                        4'd5:    cur_d.ctrl = sym;
                        4'd6:    cur_d.ts2  = (sym == TS2_ID);
                        default: ;
                    endcase
                    if (sym_ok) begin
                        if (idx_d == 4'd15) begin
                            done_d   = 1'b1;
                            state_d  = ST_IDLE;
                            idx_d    = 4'd0;
                            // A zero count (fresh or after an abort) always restarts at 1.
                            if (cur_d == last_d) begin
                                count_d = (count_d == CONSEC_MAX) ? CONSEC_MAX : count_d + 4'd1;
                            end else begin
                                count_d = 4'd1;
                            end
                            last_d   = cur_d;
                            fields_d = cur_d;
                        end else begin
                            idx_d = idx_d + 4'd1;
                            if (idx_d == 4'd6) begin
                                state_d = ST_ID;
                            end
                        end
                    end else begin
                        count_d = 4'd0;
                        if (sym_com) begin
                            state_d = ST_HDR;
                            idx_d   = 4'd1;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = 4'd0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            cur_q    <= '0;
            last_q   <= '0;
            fields_q <= '0;
            count_q  <= 4'd0;
            done_q   <= 1'b0;
        end else if (!en_i) begin
            // Disabled lane drops any partial TS; captured fields are kept.
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            count_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            fields_q <= fields_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign ts_valid_o = done_q;
    assign fields_o   = fields_q;
    assign ts_count_o = count_q;

endmodule

// File: rtl/rx_ts_decoder.sv
// Gen1/Gen2 TS1/TS2 decoder: one parser per lane, enabled only at Gen1/Gen2 and for active lanes.
module rx_ts_decoder
    import rx_ts_decoder_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2:0]                     GEN,
    input  logic [4:0]                     LANESNUMBER,
    input  logic [LANES-1:0]               LMCValid,
    input  logic [LANES*SYM_PER_LANE*8-1:0] LMCData,
    input  logic [LANES*SYM_PER_LANE-1:0]  LMCDataK,
    output logic [LANES-1:0]               tsValid,
    output logic [LANES-1:0]               tsType,
    output logic [LANES*8-1:0]             linkNumber,
    output logic [LANES-1:0]               linkPad,
    output logic [LANES*8-1:0]             laneNumber,
    output logic [LANES-1:0]               lanePad,
    output logic [LANES*8-1:0]             nFTS,
    output logic [LANES*8-1:0]             rateId,
    output logic [LANES*8-1:0]             trainCtrl,
    output logic [LANES*4-1:0]             tsCount
);

    logic gen_ok;
    assign gen_ok = (GEN == GEN1) || (GEN == GEN2);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            ts_fields_t fields;
            logic       lane_en;

            assign lane_en = gen_ok && (5'(gi) < LANESNUMBER);

            ts_lane_parser u_parser (
                .clk        (clk),
                .srst_i     (reset),
                .en_i       (lane_en),
                .valid_i    (LMCValid[gi]),
                .data_i     (LMCData[gi*SYM_PER_LANE*8 +: SYM_PER_LANE*8]),
                .datak_i    (LMCDataK[gi*SYM_PER_LANE +: SYM_PER_LANE]),
                .ts_valid_o (tsValid[gi]),
                .fields_o   (fields),
                .ts_count_o (tsCount[gi*4 +: 4])
            );

            assign tsType[gi]            = fields.ts2;
            assign linkNumber[gi*8 +: 8] = fields.link;
            assign linkPad[gi]           = fields.link_pad;
            assign laneNumber[gi*8 +: 8] = fields.lane;
            assign lanePad[gi]           = fields.lane_pad;
            assign nFTS[gi*8 +: 8]       = fields.nfts;
            assign rateId[gi*8 +: 8]     = fields.rate;
            assign trainCtrl[gi*8 +: 8]  = fields.ctrl;
        end
    endgenerate

endmodule

// File: tb/tb_rx_ts_decoder.sv
// Randomized bench for rx_ts_decoder against a buffer-based reference model of TS recognition.
`timescale 1ns/1ps
module tb_rx_ts_decoder;

    localparam int LANES = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   GEN;
    logic [4:0]   LANESNUMBER;
    logic [15:0]  LMCValid;
    logic [511:0] LMCData;
    logic [63:0]  LMCDataK;
    logic [15:0]  tsValid, tsType, linkPad, lanePad;
    logic [127:0] linkNumber, laneNumber, nFTS, rateId, trainCtrl;
    logic [63:0]  tsCount;

    always #5 clk = ~clk;

    rx_ts_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .GEN         (GEN),
        .LANESNUMBER (LANESNUMBER),
        .LMCValid    (LMCValid),
        .LMCData     (LMCData),
        .LMCDataK    (LMCDataK),
        .tsValid     (tsValid),
        .tsType      (tsType),
        .linkNumber  (linkNumber),
        .linkPad     (linkPad),
        .laneNumber  (laneNumber),
        .lanePad     (lanePad),
        .nFTS        (nFTS),
        .rateId      (rateId),
        .trainCtrl   (trainCtrl),
        .tsCount     (tsCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Symbols are 9 bits: {K, value}.
    logic [8:0]  stream [LANES][$];
    logic [8:0]  mbuf   [LANES][$];
    logic [53:0] last_key [LANES];
    int          m_cnt [LANES];
    logic [42:0] pool [LANES][2];
    int          pick [LANES];

    logic [15:0]  e_valid, e_type, e_lpad, e_npad;
    logic [127:0] e_link, e_lane, e_nfts, e_rate, e_ctrl;
    logic [63:0]  e_count;

    // True when every symbol after the COM obeys its positional rule.
    function automatic bit prefix_ok(input logic [8:0] q[$]);
        logic [8:0] id;
        id = (q.size() > 6) ? q[6] : 9'h000;
        for (int j = 1; j < q.size(); j++) begin
            logic [8:0] t;
            t = q[j];
            if (j <= 2) begin
                if (t[8] && t[7:0] != 8'hF7) return 1'b0;
            end else if (j <= 5) begin
                if (t[8]) return 1'b0;
            end else if (j == 6) begin
                if (t[8] || (t[7:0] != 8'h4A && t[7:0] != 8'h45)) return 1'b0;
            end else begin
                if (t != id) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model_sym(input int l, input logic [8:0] sym);
        logic [8:0]  s1, s2, s3, s4, s5, s6;
        logic [53:0] key;
        bit          com;
        com = (sym == 9'h1BC);
        if (mbuf[l].size() == 0) begin
            if (com) mbuf[l].push_back(sym);
            return;
        end
        mbuf[l].push_back(sym);
        if (!prefix_ok(mbuf[l])) begin
            m_cnt[l] = 0;
            mbuf[l].delete();
            if (com) mbuf[l].push_back(sym);
        end else if (mbuf[l].size() == 16) begin
            s1 = mbuf[l][1]; s2 = mbuf[l][2]; s3 = mbuf[l][3];
            s4 = mbuf[l][4]; s5 = mbuf[l][5]; s6 = mbuf[l][6];
            key = {s1, s2, s3, s4, s5, s6};
            if (key == last_key[l]) m_cnt[l] = (m_cnt[l] < 15) ? m_cnt[l] + 1 : 15;
            else                    m_cnt[l] = 1;
            last_key[l] = key;
            e_valid[l] = 1'b1;
            e_type[l]  = (s6[7:0] == 8'h45);
            e_lpad[l]  = s1[8];
            e_npad[l]  = s2[8];
            e_link[l*8 +: 8] = s1[7:0];
            e_lane[l*8 +: 8] = s2[7:0];
            e_nfts[l*8 +: 8] = s3[7:0];
            e_rate[l*8 +: 8] = s4[7:0];
            e_ctrl[l*8 +: 8] = s5[7:0];
            mbuf[l].delete();
        end
        e_count[l*4 +: 4] = 4'(m_cnt[l]);
    endtask

    task automatic model_step();
        bit gen_ok;
        e_valid = '0;
        if (reset) begin
            {e_type, e_lpad, e_npad} = '0;
            {e_link, e_lane, e_nfts, e_rate, e_ctrl} = '0;
            e_count = '0;
            for (int l = 0; l < LANES; l++) begin
                mbuf[l].delete();
                m_cnt[l] = 0;
                last_key[l] = '0;
            end
            return;
        end
        gen_ok = (GEN == 3'd1) || (GEN == 3'd2);
        for (int l = 0; l < LANES; l++) begin
            if (!gen_ok || l >= int'(LANESNUMBER)) begin
                mbuf[l].delete();
                m_cnt[l] = 0;
                e_count[l*4 +: 4] = 4'd0;
            end else if (LMCValid[l]) begin
                for (int s = 0; s < 4; s++) begin
                    model_sym(l, {LMCDataK[l*4 + s], LMCData[l*32 + s*8 +: 8]});
                end
            end
        end
    endtask

    // Pool entry: {ts2, sym1[8:0], sym2[8:0], nfts, rate, ctrl}.
    function automatic logic [42:0] rand_entry();
        logic [8:0] s1, s2;
        s1 = ($urandom_range(0, 3) == 0) ? 9'h1F7 : {1'b0, 8'($urandom)};
        s2 = ($urandom_range(0, 3) == 0) ? 9'h1F7 : {1'b0, 8'($urandom)};
        return {1'($urandom), s1, s2, 8'($urandom), 8'($urandom), 8'($urandom)};
    endfunction

    // kind: 0 flip K, 1 insert COM, 2 alter value, 3 value 4B and truncate there.
    task automatic push_ts(input int l, input logic [42:0] e, input int bad, input int kind);
        logic [8:0] t [16];
        int         last;
        t[0] = 9'h1BC;
        t[1] = e[41:33];
        t[2] = e[32:24];
        t[3] = {1'b0, e[23:16]};
        t[4] = {1'b0, e[15:8]};
        t[5] = {1'b0, e[7:0]};
        for (int j = 6; j < 16; j++) t[j] = e[42] ? 9'h045 : 9'h04A;
        last = 15;
        if (bad != 0) begin
            case (kind)
                0:       t[bad] = t[bad] ^ 9'h100;
                1:       t[bad] = 9'h1BC;
                2:       t[bad] = t[bad] ^ 9'h001;
                default: begin t[bad] = 9'h04B; last = bad; end
            endcase
        end
        for (int j = 0; j <= last; j++) stream[l].push_back(t[j]);
    endtask

    task automatic gen_random(input int l);
        int gap, bad;
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
        repeat (gap) stream[l].push_back(($urandom_range(0, 9) == 0) ? 9'h11C : {1'b0, 8'($urandom)});
        if ($urandom_range(0, 99) < 15) pick[l] = $urandom_range(0, 1);
        if ($urandom_range(0, 99) < 3)  pool[l][pick[l]] = rand_entry();
        bad = ($urandom_range(0, 99) < 8) ? $urandom_range(1, 15) : 0;
        push_ts(l, pool[l][pick[l]], bad, $urandom_range(0, 3));
    endtask

    task automatic drive(input logic rst, input logic [2:0] g, input logic [4:0] ln, input logic [15:0] v);
        logic [8:0] sym;
        reset = rst; GEN = g; LANESNUMBER = ln; LMCValid = v;
        for (int l = 0; l < LANES; l++) begin
            if (v[l]) begin
                while (stream[l].size() < 4) gen_random(l);
                for (int s = 0; s < 4; s++) begin
                    sym = stream[l].pop_front();
                    LMCDataK[l*4 + s]       = sym[8];
                    LMCData[l*32 + s*8 +: 8] = sym[7:0];
                end
            end else begin
                LMCData[l*32 +: 32] = $urandom;
                LMCDataK[l*4 +: 4]  = 4'($urandom);
            end
        end
        model_step();
    endtask

    task automatic compare_outputs();
        check_eq("tsValid",    128'(tsValid),    128'(e_valid));
        check_eq("tsType",     128'(tsType),     128'(e_type));
        check_eq("linkPad",    128'(linkPad),    128'(e_lpad));
        check_eq("lanePad",    128'(lanePad),    128'(e_npad));
        check_eq("tsCount",    128'(tsCount),    128'(e_count));
        check_eq("linkNumber", linkNumber, e_link);
        check_eq("laneNumber", laneNumber, e_lane);
        check_eq("nFTS",       nFTS,       e_nfts);
        check_eq("rateId",     rateId,     e_rate);
        check_eq("trainCtrl",  trainCtrl,  e_ctrl);
    endtask

    localparam logic [42:0] SPEC_TS1 = {1'b0, 9'h000, 9'h000, 8'h1F, 8'h02, 8'h00};
    localparam logic [42:0] PAD_TS2  = {1'b1, 9'h1F7, 9'h1F7, 8'h1F, 8'h02, 8'h00};

    initial begin
        logic [2:0]  g;
        logic [4:0]  ln;
        logic [15:0] v;
        for (int l = 0; l < LANES; l++) begin
            pool[l][0] = rand_entry();
            pool[l][1] = rand_entry();
            pick[l] = 0;
        end
        // Lane 0 directed sequence, checked through the same model.
        push_ts(0, SPEC_TS1, 0, 0);
        stream[0].push_back(9'h000);
        stream[0].push_back(9'h000);
        repeat (20) push_ts(0, SPEC_TS1, 0, 0);
        push_ts(0, PAD_TS2, 0, 0);
        push_ts(0, SPEC_TS1, 0, 0);
        push_ts(0, SPEC_TS1, 9, 3);
        push_ts(0, SPEC_TS1, 0, 0);

        drive(1'b1, 3'd1, 5'd1, 16'h0000);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compare_outputs();
            drive(1'b1, 3'd1, 5'd1, 16'h0000);
        end
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            compare_outputs();
            v = (c >= 40 && c < 43) ? 16'hFFFE : 16'hFFFF;
            drive(1'b0, 3'd1, 5'd1, v);
        end

        g = 3'd1;
        ln = 5'd16;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            compare_outputs();
            if (c % 40 == 0) begin
                int r;
                r = $urandom_range(0, 99);
                g = (r < 45) ? 3'd1 : (r < 90) ? 3'd2 : ((r < 95) ? 3'd0 : 3'($urandom_range(3, 7)));
                ln = ($urandom_range(0, 99) < 75) ? 5'd16 : 5'($urandom_range(1, 16));
            end
            for (int l = 0; l < LANES; l++) v[l] = ($urandom_range(0, 99) < 85);
            drive(($urandom_range(0, 299) == 0), g, ln, v);
        end
        @(negedge clk);
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
